// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - Access-size encodings carried on req_size.
//   - FSM state encoding for the top-level sequencer.
//   - is_misaligned(): decides whether a request is rejected before
//     any memory access is made.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Rejects half accesses on odd bytes, word accesses off a word
  // boundary, and the unused size code.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] ofs);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = ofs[0];
      SZ_WORD: bad = (ofs != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational lane steering for sub-word accesses
// on a little-endian, word-wide memory.
// Ports:
//   size, ofs      : access size and byte offset addr[1:0]
//   is_unsigned    : zero-extend (1) or sign-extend (0) loads
//   old_word       : word currently in memory (store merge input)
//   new_data       : right-aligned store data
//   merged_word    : old_word with the addressed lane(s) replaced
//   load_word      : word read from memory (load extract input)
//   load_data      : selected lane, extended to 32 bits
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged_word,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  // Store merge, one byte lane per iteration. A lane is overwritten when
  // it falls inside the access; its source byte is taken from the
  // right-aligned store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_sel;
      logic [7:0] lane_src;

      always_comb begin
        lane_sel = 1'b0;
        lane_src = new_data[8*gi +: 8];
        case (size)
          SZ_BYTE: begin
            lane_sel = (ofs == 2'(gi));
            lane_src = new_data[7:0];
          end
          SZ_HALF: begin
            lane_sel = (ofs[1] == 1'(gi / 2));
            lane_src = new_data[8*(gi % 2) +: 8];
          end
          SZ_WORD: begin
            lane_sel = 1'b1;
            lane_src = new_data[8*gi +: 8];
          end
          default: begin
            lane_sel = 1'b0;
            lane_src = new_data[8*gi +: 8];
          end
        endcase
      end

      assign merged_word[8*gi +: 8] = lane_sel ? lane_src : old_word[8*gi +: 8];
    end
  endgenerate

  // Load extract and extend.
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = load_word[{ofs, 3'b000} +: 8];
  assign half_val = ofs[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_val}
                                       : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: load_data = is_unsigned ? {16'h0, half_val}
                                       : {{16{half_val[15]}}, half_val};
      SZ_WORD: load_data = load_word;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port. Accepts one
// load/store at a time, adds byte/half accesses over a word-only memory
// (extension on loads, read-modify-write on sub-word stores) and flags
// misaligned or illegal-size requests.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 : request fields
//   rsp_valid, rsp_rdata,
//   rsp_err                   : one-cycle completion with result
//   mem_addr, mem_wdata,
//   mem_read, mem_write       : memory bus (word address)
//   mem_rdata                 : combinational memory read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_reg;
  logic              ready_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [1:0]        ofs_reg;
  logic [DATA_W-1:0] data_reg;

  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] load_data;
  logic              req_bad;

  assign req_bad = is_misaligned(req_size, req_addr[1:0]);

  // Merge and extract both work on the word the memory is presenting in
  // READ, so the merged store word can be registered for the WRITE cycle
  // and the extended load result registered for RESP.
  lsu_byte_lane u_lane (
    .size        (size_reg),
    .ofs         (ofs_reg),
    .is_unsigned (unsigned_reg),
    .old_word    (mem_rdata),
    .new_data    (data_reg),
    .merged_word (merged_word),
    .load_word   (mem_rdata),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      we_reg        <= 1'b0;
      size_reg      <= SZ_BYTE;
      unsigned_reg  <= 1'b0;
      ofs_reg       <= 2'b00;
      data_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && ready_reg) begin
            we_reg        <= req_we;
            size_reg      <= req_size;
            unsigned_reg  <= req_unsigned;
            ofs_reg       <= req_addr[1:0];
            data_reg      <= req_wdata;
            mem_addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
            rsp_err_reg   <= req_bad;
            rsp_rdata_reg <= '0;
            ready_reg     <= 1'b0;
            if (req_bad) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
            end else if (req_we && req_size == SZ_WORD) begin
              // Full-word store needs no read; write the data directly.
              state_reg     <= ST_WRITE;
              mem_wdata_reg <= req_wdata;
            end else begin
              state_reg <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (we_reg) begin
            mem_wdata_reg <= merged_word;
            state_reg     <= ST_WRITE;
          end else begin
            rsp_rdata_reg <= load_data;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_reg <= 1'b0;
          ready_reg     <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          ready_reg     <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  // Enables are decoded straight from state so an asynchronous reset
  // removes a pending write in the same instant.
  assign mem_read  = (state_reg == ST_READ);
  assign mem_write = (state_reg == ST_WRITE);

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on posedge.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  // Results of the most recent transaction.
  int          lat;
  int          nread;
  int          nwrite;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [31:0] waddr;
  logic [31:0] wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = data;
    lat = 0; nread = 0; nwrite = 0;
    o_rdata = 32'hx; o_err = 1'bx; waddr = 32'hx; wdata = 32'hx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_read) nread++;
      if (mem_write) begin
        nwrite++;
        waddr = mem_addr;
        wdata = mem_wdata;
      end
      if (rsp_valid) begin
        lat     = k;
        o_rdata = rsp_rdata;
        o_err   = rsp_err;
        break;
      end
    end
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d reads=%0d writes=%0d",
             we, size, uns, addr, data, lat, o_rdata, o_err, nread, nwrite);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8'h20 >> 2] = 32'h11223344;
    mem[8'h30 >> 2] = 32'h80FF7F01;
    mem[8'h24 >> 2] = 32'h55667788;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",     {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_read",  {31'b0, mem_read},  32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr",  mem_addr,  32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // sw 0xDEADBEEF @0x10
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_lat",    lat, 32'd2);
    chk("sw_writes", nwrite, 32'd1);
    chk("sw_reads",  nread, 32'd0);
    chk("sw_waddr",  waddr, 32'h10);
    chk("sw_wdata",  wdata, 32'hDEADBEEF);
    chk("sw_err",    {31'b0, o_err}, 32'd0);
    chk("sw_mem",    mem[4], 32'hDEADBEEF);

    // lw @0x10
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_lat",   lat, 32'd2);
    chk("lw_reads", nread, 32'd1);
    chk("lw_data",  o_rdata, 32'hDEADBEEF);
    chk("lw_err",   {31'b0, o_err}, 32'd0);

    // sb 0xAA @0x21 over 0x11223344
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    chk("sb_lat",    lat, 32'd3);
    chk("sb_reads",  nread, 32'd1);
    chk("sb_writes", nwrite, 32'd1);
    chk("sb_waddr",  waddr, 32'h20);
    chk("sb_wdata",  wdata, 32'h1122AA44);
    chk("sb_rdata",  o_rdata, 32'h0);

    // sh 0xBEEF @0x26 over 0x55667788
    do_req(1'b1, 2'b01, 1'b0, 32'h26, 32'h1234BEEF);
    chk("sh_lat",   lat, 32'd3);
    chk("sh_wdata", wdata, 32'hBEEF7788);
    chk("sh_mem",   mem[9], 32'hBEEF7788);

    // byte/half loads from 0x80FF7F01
    do_req(1'b0, 2'b00, 1'b0, 32'h32, 32'h0);
    chk("lb_32", o_rdata, 32'hFFFFFFFF);
    chk("lb_32_lat", lat, 32'd2);
    do_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0);
    chk("lbu_33", o_rdata, 32'h00000080);
    do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0);
    chk("lb_31", o_rdata, 32'h0000007F);
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    chk("lh_32", o_rdata, 32'hFFFF80FF);
    do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    chk("lhu_32", o_rdata, 32'h000080FF);
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
    chk("lh_30", o_rdata, 32'h00007F01);

    // errors
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    chk("lw12_lat", lat, 32'd1);
    chk("lw12_err", {31'b0, o_err}, 32'd1);
    chk("lw12_rdata", o_rdata, 32'h0);
    chk("lw12_mem_ops", nread + nwrite, 32'd0);
    do_req(1'b1, 2'b01, 1'b0, 32'h23, 32'h5555);
    chk("sh23_lat", lat, 32'd1);
    chk("sh23_err", {31'b0, o_err}, 32'd1);
    chk("sh23_rdata", o_rdata, 32'h0);
    chk("sh23_mem_ops", nread + nwrite, 32'd0);
    chk("sh23_mem", mem[8], 32'h1122AA44);
    do_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
    chk("sz3_lat", lat, 32'd1);
    chk("sz3_err", {31'b0, o_err}, 32'd1);
    chk("sz3_rdata", o_rdata, 32'h0);
    chk("sz3_mem_ops", nread + nwrite, 32'd0);

    // reset during WRITE of sb 0x00 @0x24
    @(negedge clk);
    chk("rw_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h24; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_in_read", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    chk("rw_in_write", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_write_drop", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_mem", mem[9], 32'hBEEF7788);
    chk("rw_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rw_rsp_valid2", {31'b0, rsp_valid}, 32'd0);
    $display("txn reset-in-write sb addr=00000024 -> mem=%h", mem[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
